// File: rtl/mmcm_lock_sequencer.sv
// Supervises the MMCM from the free-running board clock: pulses its reset, waits for a
// stable LOCKED, releases downstream reset, and retries a bounded number of times before faulting.
`timescale 1ns/1ps
module mmcm_lock_sequencer #(
   parameter int RST_PULSE      = 16,
   parameter int HOLDOFF_CYCLES = 1024,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int MAX_RETRIES    = 7
) (
   input  logic       CLK_IN1,
   input  logic       RESET_N,
   input  logic       LOCKED,
   input  logic       FORCE_RESEAT,
   output logic       MMCM_RESET,
   output logic       SYS_RESET_N,
   output logic       READY,
   output logic       FAULT,
   output logic [2:0] RETRY_CNT
);
   localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
   localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam int TW = $clog2(LOCK_TIMEOUT);
   localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF_CYCLES - 1);
   localparam logic [TW-1:0] WAIT_LAST  = TW'(LOCK_TIMEOUT - 1);
   localparam logic [2:0]    RETRY_MAX  = 3'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_PULSE,
      ST_WAIT_LOCK,
      ST_HOLDOFF,
      ST_RUN,
      ST_FAULT
   } state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] pulse_cnt, pulse_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic [TW-1:0] wait_cnt, wait_nxt;
   logic [2:0]    retry_nxt;
   logic          lk_meta, lk_s;

   always_ff @(posedge CLK_IN1 or negedge RESET_N) begin
      if (!RESET_N) begin
         lk_meta <= 1'b0;
         lk_s    <= 1'b0;
      end else begin
         lk_meta <= LOCKED;
         lk_s    <= lk_meta;
      end
   end

   // Each counter is cleared by whichever transition enters its state, so it starts fresh there.
   always_comb begin
      state_nxt = state;
      pulse_nxt = pulse_cnt;
      hold_nxt  = hold_cnt;
      wait_nxt  = wait_cnt;
      retry_nxt = RETRY_CNT;
      if (FORCE_RESEAT) begin
         state_nxt = ST_PULSE;
         pulse_nxt = '0;
         retry_nxt = '0;
      end else begin
         case (state)
            ST_PULSE: begin
               if (pulse_cnt == PULSE_LAST) begin
                  state_nxt = ST_WAIT_LOCK;
                  wait_nxt  = '0;
               end else begin
                  pulse_nxt = pulse_cnt + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (lk_s) begin
                  state_nxt = ST_HOLDOFF;
                  hold_nxt  = '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  if (RETRY_CNT < RETRY_MAX) begin
                     retry_nxt = RETRY_CNT + 3'd1;
                     state_nxt = ST_PULSE;
                     pulse_nxt = '0;
                  end else begin
                     state_nxt = ST_FAULT;
                  end
               end else begin
                  wait_nxt = wait_cnt + 1'b1;
               end
            end
            ST_HOLDOFF: begin
               if (!lk_s) begin
                  state_nxt = ST_WAIT_LOCK;
                  wait_nxt  = '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state_nxt = ST_RUN;
               end else begin
                  hold_nxt = hold_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (!lk_s) begin
                  state_nxt = ST_WAIT_LOCK;
                  wait_nxt  = '0;
               end
            end
            ST_FAULT: begin
               state_nxt = ST_FAULT;
            end
            default: begin
               state_nxt = ST_PULSE;
               pulse_nxt = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge CLK_IN1 or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= ST_PULSE;
         pulse_cnt   <= '0;
         hold_cnt    <= '0;
         wait_cnt    <= '0;
         RETRY_CNT   <= '0;
         MMCM_RESET  <= 1'b1;
         SYS_RESET_N <= 1'b0;
         READY       <= 1'b0;
         FAULT       <= 1'b0;
      end else begin
         state       <= state_nxt;
         pulse_cnt   <= pulse_nxt;
         hold_cnt    <= hold_nxt;
         wait_cnt    <= wait_nxt;
         RETRY_CNT   <= retry_nxt;
         MMCM_RESET  <= (state_nxt == ST_PULSE) || (state_nxt == ST_FAULT);
         SYS_RESET_N <= (state_nxt == ST_RUN);
         READY       <= (state_nxt == ST_RUN);
         FAULT       <= (state_nxt == ST_FAULT);
      end
   end
endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Bench for mmcm_lock_sequencer: directed lock/retry/fault scenarios with literal
// expectations, then random LOCKED/reseat/reset traffic checked against a timing model.
`timescale 1ns/1ps
module tb_mmcm_lock_sequencer;
   localparam int RST_PULSE      = 4;
   localparam int HOLDOFF_CYCLES = 8;
   localparam int LOCK_TIMEOUT   = 32;
   localparam int MAX_RETRIES    = 2;

   localparam int M_PULSE = 0;
   localparam int M_WAIT  = 1;
   localparam int M_HOLD  = 2;
   localparam int M_RUN   = 3;
   localparam int M_FAULT = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       locked = 1'b0;
   logic       force_reseat = 1'b0;
   logic       mmcm_reset;
   logic       sys_reset_n;
   logic       ready;
   logic       fault;
   logic [2:0] retry_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   int m_mode    = M_PULSE;
   int m_elapsed = 0;
   int m_retries = 0;
   bit m_s1 = 1'b0;
   bit m_s2 = 1'b0;
   bit m_lks = 1'b0;

   mmcm_lock_sequencer #(
      .RST_PULSE(RST_PULSE),
      .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
      .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .MAX_RETRIES(MAX_RETRIES)
   ) dut (
      .CLK_IN1(clk),
      .RESET_N(rst_n),
      .LOCKED(locked),
      .FORCE_RESEAT(force_reseat),
      .MMCM_RESET(mmcm_reset),
      .SYS_RESET_N(sys_reset_n),
      .READY(ready),
      .FAULT(fault),
      .RETRY_CNT(retry_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input int expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Inputs are driven and outputs read 1ns after the falling edge, well away from the rising edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic int model_vec();
      bit mr, run, ft;
      mr  = (m_mode == M_PULSE) || (m_mode == M_FAULT);
      run = (m_mode == M_RUN);
      ft  = (m_mode == M_FAULT);
      return int'({mr, run, run, ft, 3'(m_retries)});
   endfunction

   // Model: phases measured by elapsed cycles since the phase began, lock seen two samples late.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_mode    = M_PULSE;
         m_elapsed = 0;
         m_retries = 0;
         m_s1      = 1'b0;
         m_s2      = 1'b0;
      end else begin
         m_lks = m_s2;
         m_s2  = m_s1;
         m_s1  = locked;
         m_elapsed++;
         if (force_reseat) begin
            m_mode    = M_PULSE;
            m_elapsed = 0;
            m_retries = 0;
         end else if (m_mode == M_PULSE) begin
            if (m_elapsed == RST_PULSE) begin
               m_mode = M_WAIT;
               m_elapsed = 0;
            end
         end else if (m_mode == M_WAIT) begin
            if (m_lks) begin
               m_mode = M_HOLD;
               m_elapsed = 0;
            end else if (m_elapsed == LOCK_TIMEOUT) begin
               m_elapsed = 0;
               if (m_retries < MAX_RETRIES) begin
                  m_retries++;
                  m_mode = M_PULSE;
               end else begin
                  m_mode = M_FAULT;
               end
            end
         end else if (m_mode == M_HOLD) begin
            if (!m_lks) begin
               m_mode = M_WAIT;
               m_elapsed = 0;
            end else if (m_elapsed == HOLDOFF_CYCLES) begin
               m_mode = M_RUN;
               m_elapsed = 0;
            end
         end else if (m_mode == M_RUN) begin
            if (!m_lks) begin
               m_mode = M_WAIT;
               m_elapsed = 0;
            end
         end
      end
   end

   initial forever begin
      step();
      if (chk_en)
         check("cycle", 32'({mmcm_reset, sys_reset_n, ready, fault, retry_cnt}), model_vec());
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cnt;
      #3 rst_n = 1'b0;
      step();
      chk_en = 1'b1;
      check("reset_mmcm", mmcm_reset, 1);
      check("reset_sys", sys_reset_n, 0);
      check("reset_ready", ready, 0);
      check("reset_fault", fault, 0);
      check("reset_retry", retry_cnt, 0);
      step();

      // Normal lock after release
      rst_n = 1'b1;
      cnt = 0;
      while (mmcm_reset && cnt < 20) begin
         cnt++;
         step();
      end
      check("pulse_len", cnt, 4);
      repeat (6) step();
      locked = 1'b1;
      cnt = 0;
      while (!sys_reset_n && cnt < 40) begin
         step();
         cnt++;
      end
      check("release_latency", cnt, 11);
      check("release_ready", ready, 1);
      check("release_retry", retry_cnt, 0);
      repeat (5) step();

      // Lock loss in RUN
      locked = 1'b0;
      cnt = 0;
      while (sys_reset_n && cnt < 10) begin
         step();
         cnt++;
      end
      check("loss_latency", cnt, 3);
      check("loss_mmcm", mmcm_reset, 0);

      // Glitch during holdoff
      repeat (3) step();
      locked = 1'b1;
      repeat (5) step();
      locked = 1'b0;
      step();
      locked = 1'b1;
      cnt = 0;
      while (!sys_reset_n && cnt < 40) begin
         step();
         cnt++;
      end
      check("glitch_release", cnt, 11);
      repeat (3) step();

      // Timeouts, retries, then fault
      locked = 1'b0;
      cnt = 0;
      while (sys_reset_n && cnt < 10) begin
         step();
         cnt++;
      end
      for (int r = 1; r <= MAX_RETRIES; r++) begin
         cnt = 0;
         while (!mmcm_reset && cnt < 60) begin
            step();
            cnt++;
         end
         check("timeout_len", cnt, 32);
         check("retry_value", retry_cnt, r);
         cnt = 0;
         while (mmcm_reset && cnt < 20) begin
            cnt++;
            step();
         end
         check("retry_pulse_len", cnt, 4);
      end
      cnt = 0;
      while (!fault && cnt < 60) begin
         step();
         cnt++;
      end
      check("fault_wait", cnt, 32);
      check("fault_mmcm", mmcm_reset, 1);
      check("fault_retry", retry_cnt, 2);
      locked = 1'b1;
      repeat (20) step();
      check("fault_sticky", fault, 1);
      check("fault_sys", sys_reset_n, 0);

      // Recovery via reseat
      force_reseat = 1'b1;
      step();
      force_reseat = 1'b0;
      check("reseat_fault", fault, 0);
      check("reseat_retry", retry_cnt, 0);
      cnt = 0;
      while (mmcm_reset && cnt < 20) begin
         cnt++;
         step();
      end
      check("reseat_pulse", cnt, 4);
      cnt = 0;
      while (!ready && cnt < 40) begin
         step();
         cnt++;
      end
      check("reseat_ready", ready, 1);

      // Asynchronous reset in the middle of holdoff, between clock edges
      force_reseat = 1'b1;
      step();
      force_reseat = 1'b0;
      repeat (6) step();
      check("pre_async_mmcm", mmcm_reset, 0);
      #2 rst_n = 1'b0;
      #1;
      check("async_mmcm", mmcm_reset, 1);
      check("async_sys", sys_reset_n, 0);
      check("async_ready", ready, 0);
      check("async_fault", fault, 0);
      check("async_retry", retry_cnt, 0);
      step();
      step();
      rst_n = 1'b1;

      // Random LOCKED activity with occasional reseats and resets
      for (int i = 0; i < 200; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 8) begin
            force_reseat = 1'b1;
            step();
            force_reseat = 1'b0;
         end else if (r < 11) begin
            #2 rst_n = 1'b0;
            repeat (int'($urandom_range(1, 3))) step();
            rst_n = 1'b1;
         end else begin
            locked = 1'($urandom_range(0, 1));
            if (locked)
               repeat (int'($urandom_range(1, 25))) step();
            else
               repeat (int'($urandom_range(1, 80))) step();
         end
      end
      repeat (5) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mmcm_lock_sequencer.md
Name: mmcm_lock_sequencer

Overview:
Consumer of the clock wizard's status interface. It drives the MMCM's active-high RESET, watches LOCKED, and releases a clean reset to the camera and VGA logic only after lock has been stable. On lock loss it re-asserts the downstream reset. If lock does not return, it retries a bounded number of times, then flags a fault. It runs on the free-running 100 MHz board clock that feeds the MMCM input, so it never depends on the clocks it supervises.

Parameters:
RST_PULSE, 16, cycles MMCM_RESET is held high per reset attempt (>=1)
HOLDOFF_CYCLES, 1024, consecutive synchronized-LOCKED-high cycles required before downstream reset release (>=1)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a reset retry (>=2)
MAX_RETRIES, 7, reset retries allowed before FAULT (1..7; RETRY_CNT is 3 bits)

Ports:
CLK_IN1  input  1  100 MHz free-running board clock; all logic on rising edge
RESET_N  input  1  asynchronous active-low reset
LOCKED  input  1  MMCM LOCKED, asynchronous to CLK_IN1; passes through a 2-flop synchronizer
FORCE_RESEAT  input  1  synchronous single-cycle request to restart the sequence
MMCM_RESET  output  1  active-high reset to MMCM RST
SYS_RESET_N  output  1  active-low reset for downstream logic (registered)
READY  output  1  high in RUN
FAULT  output  1  high in FAULT
RETRY_CNT  output  3  number of reset retries since the last RESET_N or FORCE_RESEAT

Behaviour:
- All outputs are registered. While RESET_N=0: MMCM_RESET=1, SYS_RESET_N=0, READY=0, FAULT=0, RETRY_CNT=0, state=PULSE, counters=0, synchronizer=0.
- lk_s: LOCKED after the 2-flop synchronizer, 2-cycle latency. All decisions use lk_s.
- PULSE state:
  - MMCM_RESET=1 for exactly RST_PULSE cycles, counted from the first edge after RESET_N deasserts or from state entry.
  - Then go to WAIT_LOCK; MMCM_RESET=0 from that cycle on.
- WAIT_LOCK state (MMCM_RESET=0, SYS_RESET_N=0):
  - The timeout counter clears on entry.
  - lk_s=1: go to HOLDOFF.
  - Counter reaches LOCK_TIMEOUT-1 with lk_s=0 and RETRY_CNT<MAX_RETRIES: RETRY_CNT+1, go to PULSE.
  - Same condition with RETRY_CNT=MAX_RETRIES: go to FAULT.
- HOLDOFF state:
  - The holdoff counter clears on entry.
  - lk_s=0 at any point: return to WAIT_LOCK with a fresh timeout count. RETRY_CNT is unchanged.
  - HOLDOFF_CYCLES consecutive lk_s=1 cycles: go to RUN.
  - SYS_RESET_N=1 and READY=1 appear on the first RUN cycle.
- RUN state: SYS_RESET_N=1, READY=1.
  - lk_s=0: go to WAIT_LOCK. SYS_RESET_N=0 and READY=0 on the next edge, which is at most 3 edges after raw LOCKED falls.
  - The MMCM is not reset on lock loss; it relocks by itself, and WAIT_LOCK timeout covers failure.
- FAULT state: MMCM_RESET=1, SYS_RESET_N=0, FAULT=1.
  - Terminal until RESET_N or FORCE_RESEAT.
  - LOCKED is ignored.
- FORCE_RESEAT=1 in any state has priority over all other transitions:
  - Next state is PULSE; RETRY_CNT=0, FAULT=0, READY=0, SYS_RESET_N=0.
  - The pulse counter restarts.
  - FORCE_RESEAT during PULSE restarts the pulse, lengthening it.
- RETRY_CNT saturates at MAX_RETRIES and is not cleared on reaching RUN; it is a diagnostic.
- Counters are sized as clog2 of their parameter and never wrap. Each holds at its terminal value for one cycle, then the state changes.
- RESET_N assertion mid-sequence immediately, asynchronously, forces the reset values above.

Test Plan:
Sim parameters: RST_PULSE=4, HOLDOFF_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRIES=2.
- Normal lock: release RESET_N, raise LOCKED 10 cycles later -> MMCM_RESET high for exactly 4 cycles. SYS_RESET_N/READY rise 2+8 cycles after the LOCKED rise (+1 for state register). RETRY_CNT=0.
- Glitch in holdoff: LOCKED high 5 cycles, low 1 cycle, high again -> no release until 8 consecutive lk_s-high cycles after the glitch. MMCM_RESET stays 0.
- Lock loss in RUN: drop LOCKED -> SYS_RESET_N=0 within 3 cycles, MMCM_RESET stays 0. Re-raise LOCKED -> release after holdoff.
- Timeout retries: hold LOCKED=0 -> 4-cycle MMCM_RESET pulses after each 32-cycle wait, RETRY_CNT 1 then 2. Third timeout -> FAULT=1, MMCM_RESET=1; later LOCKED=1 is ignored.
- Recovery: in FAULT, pulse FORCE_RESEAT -> FAULT=0, RETRY_CNT=0, a fresh 4-cycle pulse follows, then normal lock completes.
- Async reset: assert RESET_N low mid-HOLDOFF between clock edges -> outputs take reset values without waiting for a clock edge.
